// File: rtl/pc_pkg.sv
// pc_pkg: operation-select encoding and default parameters shared by the
// program-counter sequencer and its return-address stack.
package pc_pkg;

  localparam int PC_WIDTH_DEF  = 16;
  localparam int RAS_DEPTH_DEF = 8;
  localparam int RESET_VEC_DEF = 0;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    INC    = 3'd1,
    LOAD   = 3'd2,
    BRANCH = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } op_e;

  // Fixed-priority pick of the single operation performed this cycle.
  // Anything below the winner is dropped, never queued.
  function automatic op_e pc_decode(input logic stall, input logic ret,
                                    input logic call, input logic load,
                                    input logic branch, input logic inc);
    op_e op;
    op = HOLD;
    if (stall)       op = HOLD;
    else if (ret)    op = RET;
    else if (call)   op = CALL;
    else if (load)   op = LOAD;
    else if (branch) op = BRANCH;
    else if (inc)    op = INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack. The count is reset asynchronously; the
// entries are plain storage and keep stale data across reset.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      top;

  // Occupancy counter; caller guarantees no push when full, no pop when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (push) count <= count + 1'b1;
    else if (pop)  count <= count - 1'b1;
  end

  // Entry storage, written at the current count (next free slot).
  always_ff @(posedge clk) begin
    if (push) mem[count[AW-1:0]] <= din;
  end

  assign top   = count - 1'b1;
  assign dout  = mem[top[AW-1:0]];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment/load/branch and, when
// PC_SEQUENCER_RAS_EN is defined, call/ret through a return-address stack.
// Without the macro call/ret are ignored and the stack flags are constant.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              WIDTH     = PC_WIDTH_DEF,
  parameter int              DEPTH     = RAS_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             load,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic             stall,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  input  logic             oTriEn,
  output tri   [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] pc_q,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);

  op_e              op;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_dout;
  logic             ras_full;
  logic             ras_empty;

  assign pc_inc = pc_q + 1'b1;

`ifdef PC_SEQUENCER_RAS_EN
  logic                  push;
  logic                  pop;
  logic [$clog2(DEPTH):0] ras_count;

  assign op   = pc_decode(stall, ret, call, load, branch, increment);
  assign push = (op == CALL) && !ras_full;
  assign pop  = (op == RET)  && !ras_empty;

  pc_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Sticky error: call into a full stack or ret from an empty one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (((op == CALL) && ras_full) || ((op == RET) && (ras_count == '0)))
      err <= 1'b1;
  end

  assign stack_full  = ras_full;
  assign stack_empty = ras_empty;
`else
  // No stack: call/ret behave as if deasserted, so lower requests still win.
  assign op          = pc_decode(stall, 1'b0, 1'b0, load, branch, increment);
  assign ras_dout    = '0;
  assign ras_full    = 1'b0;
  assign ras_empty   = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign err         = 1'b0;
`endif

  // PC register: one operation per cycle, selected by op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_VEC;
    else begin
      case (op)
        INC:     pc_q <= pc_inc;
        LOAD:    pc_q <= target;
        BRANCH:  pc_q <= pc_q + offset;
        CALL:    if (!ras_full)  pc_q <= target;
        RET:     if (!ras_empty) pc_q <= ras_dout;
        default: pc_q <= pc_q;
      endcase
    end
  end

  assign PC_out = oTriEn ? pc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus hand sequences for the stack,
// priority, tri-state and asynchronous-reset corner cases.
module tb_pc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         increment, load, branch, call, ret, stall, oTriEn;
  logic [W-1:0] target, offset;
  wire  [W-1:0] pc_out;
  logic [W-1:0] pc_q;
  logic         stack_full, stack_empty, err;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.WIDTH(W), .DEPTH(8), .RESET_VEC(16'h0100)) dut (
    .clk(clk), .reset(reset), .increment(increment), .load(load),
    .branch(branch), .call(call), .ret(ret), .stall(stall),
    .target(target), .offset(offset), .oTriEn(oTriEn), .PC_out(pc_out),
    .pc_q(pc_q), .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         inc, ld, br, cl, rt, st;
    logic [W-1:0] tgt, off;
    logic [W-1:0] exp_pc;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic inc, ld, br, cl, rt, st,
                       input logic [W-1:0] tgt, input logic [W-1:0] off);
    increment = inc; load = ld; branch = br; call = cl; ret = rt; stall = st;
    target = tgt; offset = off;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  // Apply current inputs across one rising edge, settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    oTriEn = 1'b1;
    idle();
    //                 inc ld br cl rt st  target    offset    exp_pc
    vt[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0101};
    vt[1]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0102};
    vt[2]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0103};
    vt[3]  = '{0, 1, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF};
    vt[4]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    vt[5]  = '{0, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFF0, 16'h0000};
    vt[7]  = '{0, 0, 1, 0, 0, 0, 16'h0000, 16'h0005, 16'h0005};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005};
    vt[9]  = '{1, 1, 1, 0, 0, 1, 16'h1234, 16'h0001, 16'h0005};
    vt[10] = '{1, 1, 1, 0, 0, 0, 16'h1234, 16'h0001, 16'h1234};
    vt[11] = '{1, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 16'h1236};

    // Reset state
    do_reset();
    chk("reset_pc", 32'(pc_q), 32'h0100);
    chk("reset_empty", 32'(stack_empty), 32'd1);
    chk("reset_full", 32'(stack_full), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Vector table: increment/load/branch/stall priority and wraparound
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].inc, vt[i].ld, vt[i].br, vt[i].cl, vt[i].rt, vt[i].st,
            vt[i].tgt, vt[i].off);
      step();
      chk($sformatf("vec%0d_pc", i), 32'(pc_q), 32'(vt[i].exp_pc));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
    end
    idle();

`ifdef PC_SEQUENCER_RAS_EN
    // ret on empty stack right after reset
    do_reset();
    drive(0, 0, 0, 0, 1, 0, '0, '0); step();
    chk("ret_empty_pc", 32'(pc_q), 32'h0100);
    chk("ret_empty_err", 32'(err), 32'd1);
    idle(); step();
    chk("err_sticky", 32'(err), 32'd1);

    // call then ret
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 16'h0020, '0); step();
    drive(0, 0, 0, 1, 0, 0, 16'h0400, '0); step();
    chk("call_pc", 32'(pc_q), 32'h0400);
    chk("call_empty", 32'(stack_empty), 32'd0);
    drive(0, 0, 0, 0, 1, 0, '0, '0); step();
    chk("ret_pc", 32'(pc_q), 32'h0021);
    chk("ret_empty", 32'(stack_empty), 32'd1);
    chk("ret_err", 32'(err), 32'd0);

    // Fill the stack, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0, 0, 16'(16'h1000 + 16 * i), '0); step();
      chk($sformatf("fill%0d_full", i), 32'(stack_full), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("fill_pc", 32'(pc_q), 32'h1070);
    drive(0, 0, 0, 1, 0, 0, 16'h9999, '0); step();
    chk("ovf_pc", 32'(pc_q), 32'h1070);
    chk("ovf_err", 32'(err), 32'd1);
    drive(1, 0, 0, 1, 0, 1, 16'h7777, '0); step();
    chk("stall_pc", 32'(pc_q), 32'h1070);
    chk("stall_full", 32'(stack_full), 32'd1);
    drive(0, 1, 0, 0, 1, 0, 16'h5555, '0); step();
    chk("retload_pc", 32'(pc_q), 32'h1061);
    chk("retload_full", 32'(stack_full), 32'd0);
    idle();
`else
    // Without the stack, call/ret are invisible to the priority chain
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 16'h0400, '0); step();
    chk("nocall_pc", 32'(pc_q), 32'h0101);
    drive(0, 1, 0, 0, 1, 0, 16'h5555, '0); step();
    chk("noret_pc", 32'(pc_q), 32'h5555);
    drive(0, 0, 0, 0, 1, 0, '0, '0); step();
    chk("noret_hold", 32'(pc_q), 32'h5555);
    chk("noras_err", 32'(err), 32'd0);
    chk("noras_empty", 32'(stack_empty), 32'd1);
    chk("noras_full", 32'(stack_full), 32'd0);
    idle();
`endif

    // Tri-state output
    do_reset();
    oTriEn = 1'b1;
    drive(1, 0, 0, 0, 0, 0, '0, '0); step();
    chk("tri_on", 32'(pc_out), 32'(pc_q));
    oTriEn = 1'b0;
    step();
    chk("tri_off_pc", 32'(pc_q), 32'h0102);
    checks++;
    if (pc_out === pc_q) begin
      errors++;
      $display("FAIL tri_off_out: got %h expected high-Z", pc_out);
    end
    step();
    chk("tri_off_count", 32'(pc_q), 32'h0103);
    oTriEn = 1'b1;

    // Asynchronous reset in mid-period
    step();
    chk("pre_async_pc", 32'(pc_q), 32'h0104);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pc", 32'(pc_q), 32'h0100);
    chk("async_empty", 32'(stack_empty), 32'd1);
    chk("async_err", 32'(err), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset_inc", 32'(pc_q), 32'h0101);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, PC width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, return-address stack entries (power of two, min 2).
REQ-003 The block SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 The ports SHALL be:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
increment  in  1  advance PC by 1
load  in  1  absolute jump to target
branch  in  1  relative jump by offset
call  in  1  push PC+1, jump to target
ret  in  1  pop stack into PC
stall  in  1  hold all state
target  in  WIDTH  absolute address for load/call
offset  in  WIDTH  two's-complement branch offset
oTriEn  in  1  output enable for PC_out
PC_out  out  WIDTH  tri-state PC; high-Z when oTriEn=0
pc_q  out  WIDTH  PC, always driven
stack_full  out  1  stack holds DEPTH entries
stack_empty  out  1  stack holds 0 entries
err  out  1  sticky overflow/underflow flag

Function
REQ-005 PC SHALL update only on rising clk; exactly one operation per cycle, priority stall > ret > call > load > branch > increment; none asserted = hold.
REQ-006 increment: PC <= PC+1 modulo 2^WIDTH (0xFFFF -> 0x0000 at WIDTH=16, no flag).
REQ-007 load: PC <= target.
REQ-008 branch: PC <= PC+offset modulo 2^WIDTH; carry discarded.
REQ-009 call with stack not full: push PC+1 (modulo 2^WIDTH), PC <= target, same cycle.
REQ-010 call with stack full: no push, PC unchanged, err <= 1.
REQ-011 ret with stack not empty: PC <= top entry, pop, same cycle.
REQ-012 ret with stack empty: PC unchanged, err <= 1.
REQ-013 Lower-priority requests asserted with a higher one SHALL be dropped, not queued.
REQ-014 stack_full, stack_empty, pc_q SHALL be registered-state derived, valid the cycle after the causing edge; no combinational path from request inputs.
REQ-015 PC_out SHALL equal pc_q when oTriEn=1, else all bits Z; oTriEn SHALL not affect state.
REQ-016 err SHALL stay 1 until reset.

Reset
REQ-017 reset=0 SHALL immediately, independent of clk: PC <= RESET_VEC, stack count <= 0, err <= 0, stack_empty=1, stack_full=0.
REQ-018 Reset asserted mid-call/ret SHALL discard the operation; stack contents need not be cleared, only the count.
REQ-019 First operation SHALL take effect on the first rising clk after reset deasserts.

Configuration
REQ-020 Macro PC_SEQUENCER_RAS_EN SHALL compile in the return-address stack.
REQ-021 Without PC_SEQUENCER_RAS_EN: call and ret SHALL be ignored (treated as none asserted, below stall, no err), stack_full=0, stack_empty=1, err=0 constant, no stack storage synthesised.

Structure
REQ-022 Shared package pc_pkg SHALL hold the operation-select encoding (HOLD, INC, LOAD, BRANCH, CALL, RET) and default parameter constants.
REQ-023 Stack SHALL be sub-module pc_ras (push, pop, data in/out, count, full, empty), instantiated only under PC_SEQUENCER_RAS_EN.

Verification
REQ-024 Reset low with RESET_VEC=0x0100, then 3 cycles increment -> pc_q 0x0100, 0x0101, 0x0102, 0x0103.
REQ-025 PC=0xFFFF, increment -> 0x0000; PC=0x0010, branch offset=0xFFF0 -> 0x0000, err=0.
REQ-026 PC=0x0020, call target=0x0400; then ret -> PC 0x0400 then 0x0021, stack_empty 0 then 1.
REQ-027 DEPTH=8: 8 calls then 9th call -> stack_full=1, 9th leaves PC unchanged, err=1; ret on empty stack after reset -> PC unchanged, err=1.
REQ-028 stall+call+increment together -> PC and count unchanged; ret+load together -> pop wins, load dropped.
REQ-029 oTriEn=0 -> PC_out all Z while pc_q counts; reset pulsed mid-clock-period -> pc_q=RESET_VEC before next edge.
